car_led_monitor: RTL and testbench

CAR_LED_MONITOR -- requirements
Module: car_led_monitor

---
 rtl/car_led_monitor.sv | 169 ++++++++++++++++
 tb/tb_car_led_monitor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/car_led_monitor.sv
// Decodes sequential turn-signal lamp patterns into a registered driving mode,
// tracks completed blink cycles and flags illegal, conflicting or stuck patterns.
module car_led_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] led_left,
  input  logic [2:0] led_right,
  output logic [2:0] mode,
  output logic       mode_valid,
  output logic       brake_flag,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       fault_sticky,
  output logic [7:0] wrap_count
);

  typedef enum logic [2:0] {
    ST_HOLD0, ST_HOLD1, ST_ADV, ST_WRAP, ST_RISE, ST_CANCEL, ST_BAD
  } step_t;

  typedef enum logic [2:0] {
    M_IDLE    = 3'd0,
    M_LEFT    = 3'd1,
    M_RIGHT   = 3'd2,
    M_HAZARD  = 3'd3,
    M_BRAKE   = 3'd4,
    M_UNKNOWN = 3'd7
  } mode_t;

  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_CONFLICT = 2'b10;
  localparam logic [1:0] FC_STUCK    = 2'b11;

  function automatic step_t classify(input logic [2:0] p, input logic [2:0] c);
    step_t s;
    case ({p, c})
      6'b000_000:                         s = ST_HOLD0;
      6'b111_111:                         s = ST_HOLD1;
      6'b000_001, 6'b001_011, 6'b011_111: s = ST_ADV;
      6'b111_000:                         s = ST_WRAP;
      6'b000_111:                         s = ST_RISE;
      6'b001_000, 6'b011_000:             s = ST_CANCEL;
      default:                            s = ST_BAD;
    endcase
    return s;
  endfunction

  logic [2:0] prev_l, prev_r;
  logic       primed;
  logic [1:0] mix_cnt;
  mode_t      mode_q, mode_n;

  step_t      sl, sr, hl, hr;
  logic       brake_n, fault_n, sticky_n, wrap_inc;
  logic [1:0] code_n, mix_n;
  logic [7:0] wc_n;
  logic       move_l, move_r, hold_l, hold_r, conflict;

  // Next-state decode: one prioritised pass over the current left/right step pair.
  always_comb begin
    sl       = classify(prev_l, led_left);
    sr       = classify(prev_r, led_right);
    hl       = (sl == ST_CANCEL) ? ST_HOLD0 : sl;
    hr       = (sr == ST_CANCEL) ? ST_HOLD0 : sr;
    move_l   = (sl == ST_ADV) || (sl == ST_WRAP);
    move_r   = (sr == ST_ADV) || (sr == ST_WRAP);
    hold_l   = (hl == ST_HOLD0) || (hl == ST_HOLD1);
    hold_r   = (hr == ST_HOLD0) || (hr == ST_HOLD1);
    conflict = ((sl == ST_ADV) && (sr == ST_ADV))
            || (move_l && (sr == ST_CANCEL))
            || (move_r && (sl == ST_CANCEL))
            || ((hl == ST_RISE) && hold_r)
            || ((hr == ST_RISE) && hold_l);

    mode_n   = mode_q;
    brake_n  = brake_flag;
    fault_n  = 1'b0;
    code_n   = fault_code;
    sticky_n = fault_sticky;
    wrap_inc = 1'b0;
    mix_n    = 2'd0;

    if ((sl == ST_BAD) || (sr == ST_BAD)) begin
      mode_n  = M_UNKNOWN;
      brake_n = 1'b0;
      fault_n = 1'b1;
      code_n  = FC_ILLEGAL;
    end else if (conflict) begin
      mode_n  = M_UNKNOWN;
      brake_n = 1'b0;
      fault_n = 1'b1;
      code_n  = FC_CONFLICT;
    end else if ((sl == ST_WRAP) && (sr == ST_WRAP)) begin
      mode_n   = M_HAZARD;
      brake_n  = 1'b0;
      wrap_inc = 1'b1;
    end else if ((sl == ST_RISE) && (sr == ST_RISE)) begin
      mode_n = mode_q;
    end else if (move_l) begin
      mode_n   = M_LEFT;
      wrap_inc = (sl == ST_WRAP);
      brake_n  = (hr == ST_HOLD1) || (hr == ST_RISE);
    end else if (move_r) begin
      mode_n   = M_RIGHT;
      wrap_inc = (sr == ST_WRAP);
      brake_n  = (hl == ST_HOLD1) || (hl == ST_RISE);
    end else if ((hl == ST_HOLD0) && (hr == ST_HOLD0)) begin
      mode_n  = M_IDLE;
      brake_n = 1'b0;
    end else if ((hl == ST_HOLD1) && (hr == ST_HOLD1)) begin
      mode_n  = M_BRAKE;
      brake_n = 1'b0;
    end else if (mix_cnt == 2'd3) begin
      mode_n  = M_UNKNOWN;
      brake_n = 1'b0;
      fault_n = 1'b1;
      code_n  = FC_STUCK;
    end else begin
      mix_n = mix_cnt + 2'd1;
    end

    if (fault_n) begin
      sticky_n = 1'b1;
    end

    // A mode change restarts the count, but the step that caused it may itself be a wrap.
    if (mode_n != mode_q) begin
      wc_n = wrap_inc ? 8'd1 : 8'd0;
    end else if (wrap_inc && (wrap_count != 8'hFF)) begin
      wc_n = wrap_count + 8'd1;
    end else begin
      wc_n = wrap_count;
    end
  end

  // The first edge after reset only captures prev; decoding starts on the second.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_l       <= 3'b000;
      prev_r       <= 3'b000;
      primed       <= 1'b0;
      mix_cnt      <= 2'd0;
      mode_q       <= M_IDLE;
      mode_valid   <= 1'b0;
      brake_flag   <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= 2'b00;
      fault_sticky <= 1'b0;
      wrap_count   <= 8'd0;
    end else begin
      prev_l <= led_left;
      prev_r <= led_right;
      primed <= 1'b1;
      if (primed) begin
        mix_cnt      <= mix_n;
        mode_q       <= mode_n;
        mode_valid   <= 1'b1;
        brake_flag   <= brake_n;
        fault        <= fault_n;
        fault_code   <= code_n;
        fault_sticky <= sticky_n;
        wrap_count   <= wc_n;
      end
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_car_led_monitor.sv
// Scoreboard bench for car_led_monitor: directed lamp scenarios plus random
// traffic, checked against a lamp-level reference model.
module tb_car_led_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] led_left = 3'b000;
  logic [2:0] led_right = 3'b000;
  logic [2:0] mode;
  logic       mode_valid, brake_flag, fault, fault_sticky;
  logic [1:0] fault_code;
  logic [7:0] wrap_count;

  car_led_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .led_left    (led_left),
    .led_right   (led_right),
    .mode        (mode),
    .mode_valid  (mode_valid),
    .brake_flag  (brake_flag),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_sticky(fault_sticky),
    .wrap_count  (wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] mode;
    logic       valid;
    logic       brake;
    logic       fault;
    logic [1:0] code;
    logic       sticky;
    logic [7:0] wc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Step kinds in the model, expressed via lamp levels
  localparam int K_H0 = 0, K_H1 = 1, K_ADV = 2, K_WRAP = 3, K_RISE = 4, K_CAN = 5, K_BAD = 6;

  int         m_mode, m_wc, m_mix, m_code;
  bit         m_valid, m_brake, m_fault, m_sticky, m_primed;
  logic [2:0] m_pl, m_pr;
  logic [2:0] pats [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

  // Number of lit lamps for a legal filling pattern, -1 otherwise
  function automatic int lvl(input logic [2:0] p);
    for (int i = 0; i < 4; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  function automatic int kind(input logic [2:0] p, input logic [2:0] c);
    int a, b;
    a = lvl(p);
    b = lvl(c);
    if (a < 0 || b < 0) return K_BAD;
    if (a == b) return (a == 0) ? K_H0 : (a == 3) ? K_H1 : K_BAD;
    if (b == a + 1) return K_ADV;
    if (a == 3 && b == 0) return K_WRAP;
    if (a == 0 && b == 3) return K_RISE;
    if (b == 0) return K_CAN;
    return K_BAD;
  endfunction

  function automatic bit is_hold(input int k);
    return (k == K_H0) || (k == K_H1);
  endfunction

  task automatic model_step(input logic rst, input logic [2:0] l, input logic [2:0] r);
    int kl, kr, ml, mr, nm, fc;
    bit inc, mvl, mvr, mixed;
    exp_t e;
    if (rst) begin
      m_mode = 0; m_wc = 0; m_mix = 0; m_code = 0;
      m_valid = 0; m_brake = 0; m_fault = 0; m_sticky = 0; m_primed = 0;
      m_pl = 3'b000; m_pr = 3'b000;
    end else if (!m_primed) begin
      m_primed = 1;
      m_pl = l; m_pr = r;
    end else begin
      kl = kind(m_pl, l);
      kr = kind(m_pr, r);
      ml = (kl == K_CAN) ? K_H0 : kl;
      mr = (kr == K_CAN) ? K_H0 : kr;
      mvl = (kl == K_ADV) || (kl == K_WRAP);
      mvr = (kr == K_ADV) || (kr == K_WRAP);
      nm = m_mode; fc = 0; inc = 0;
      mixed = (ml == K_H0 && mr == K_H1) || (ml == K_H1 && mr == K_H0);
      if (kl == K_BAD || kr == K_BAD) fc = 1;
      else if ((kl == K_ADV && kr == K_ADV) || (mvl && kr == K_CAN) || (mvr && kl == K_CAN)
               || (ml == K_RISE && is_hold(mr)) || (mr == K_RISE && is_hold(ml))) fc = 2;
      else if (kl == K_WRAP && kr == K_WRAP) begin nm = 3; inc = 1; m_brake = 0; end
      else if (kl == K_RISE && kr == K_RISE) nm = m_mode;
      else if (mvl) begin nm = 1; inc = (kl == K_WRAP); m_brake = (mr == K_H1 || mr == K_RISE); end
      else if (mvr) begin nm = 2; inc = (kr == K_WRAP); m_brake = (ml == K_H1 || ml == K_RISE); end
      else if (ml == K_H0 && mr == K_H0) begin nm = 0; m_brake = 0; end
      else if (ml == K_H1 && mr == K_H1) begin nm = 4; m_brake = 0; end
      else if (mixed && m_mix == 3) fc = 3;
      m_mix = (mixed && fc == 0) ? m_mix + 1 : 0;
      if (fc != 0) begin
        nm = 7; m_brake = 0; m_code = fc; m_sticky = 1;
      end
      m_fault = (fc != 0);
      if (nm != m_mode) m_wc = inc ? 1 : 0;
      else if (inc) m_wc = (m_wc < 255) ? m_wc + 1 : 255;
      m_mode = nm;
      m_valid = 1;
      m_pl = l; m_pr = r;
    end
    e.mode = 3'(m_mode); e.valid = m_valid; e.brake = m_brake; e.fault = m_fault;
    e.code = 2'(m_code); e.sticky = m_sticky; e.wc = 8'(m_wc);
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic rst, input logic [2:0] l, input logic [2:0] r);
    @(negedge clk);
    reset = rst;
    led_left = l;
    led_right = r;
    model_step(rst, l, r);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so each edge retires one scoreboard entry
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("mode", 8'(mode), 8'(e.mode));
      checkOutput("mode_valid", 8'(mode_valid), 8'(e.valid));
      checkOutput("brake_flag", 8'(brake_flag), 8'(e.brake));
      checkOutput("fault", 8'(fault), 8'(e.fault));
      checkOutput("fault_code", 8'(fault_code), 8'(e.code));
      checkOutput("fault_sticky", 8'(fault_sticky), 8'(e.sticky));
      checkOutput("wrap_count", wrap_count, e.wc);
    end
  end

  logic [2:0] cyc [4] = '{3'b001, 3'b011, 3'b111, 3'b000};

  task automatic doReset();
    applyStimulus(1'b1, 3'b000, 3'b000);
    applyStimulus(1'b1, 3'b000, 3'b000);
  endtask

  function automatic logic [2:0] randSide(input logic [2:0] cur);
    int v, lv;
    v = $urandom_range(0, 9);
    lv = lvl(cur);
    if (v < 4) return (lv < 0) ? 3'b000 : pats[(lv + 1) % 4];
    if (v < 6) return cur;
    if (v < 8) return 3'b000;
    if (v == 8) return 3'b111;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [2:0] rl, rr;
    int waited;

    doReset();
    applyStimulus(1'b0, 3'b000, 3'b000);

    // Left turn, three full cycles with right dark
    applyStimulus(1'b0, 3'b000, 3'b000);
    for (int n = 0; n < 3; n++)
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, cyc[i], 3'b000);

    // Right turn with left brake lamp steady, then brake reapplied mid-cycle
    doReset();
    applyStimulus(1'b0, 3'b111, 3'b000);
    applyStimulus(1'b0, 3'b111, 3'b000);
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'b111, cyc[i]);
    applyStimulus(1'b0, 3'b000, 3'b001);
    applyStimulus(1'b0, 3'b111, 3'b011);
    applyStimulus(1'b0, 3'b111, 3'b111);

    // Hazard toggling, then both held lit
    doReset();
    applyStimulus(1'b0, 3'b000, 3'b000);
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, (n % 2 == 0) ? 3'b111 : 3'b000,
                                                    (n % 2 == 0) ? 3'b111 : 3'b000);
    applyStimulus(1'b0, 3'b111, 3'b111);
    applyStimulus(1'b0, 3'b111, 3'b111);

    // Illegal pattern and recovery to a left turn
    applyStimulus(1'b0, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b101, 3'b000);
    applyStimulus(1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, cyc[i], 3'b000);

    // Mixed hold stuck, then both sides cycling together
    for (int n = 0; n < 5; n++) applyStimulus(1'b0, 3'b000, 3'b111);
    applyStimulus(1'b0, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, cyc[i], cyc[i]);

    // Reset in the middle of a turn
    applyStimulus(1'b0, 3'b001, 3'b000);
    applyStimulus(1'b0, 3'b011, 3'b000);
    applyStimulus(1'b1, 3'b111, 3'b000);
    applyStimulus(1'b0, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b001, 3'b000);

    // Hazard long enough to saturate the wrap counter
    applyStimulus(1'b0, 3'b000, 3'b000);
    for (int n = 0; n < 540; n++) applyStimulus(1'b0, (n % 2 == 0) ? 3'b111 : 3'b000,
                                                      (n % 2 == 0) ? 3'b111 : 3'b000);

    // Random traffic
    rl = 3'b000;
    rr = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        applyStimulus(1'b1, 3'b000, 3'b000);
        rl = 3'b000;
        rr = 3'b000;
      end else begin
        rl = randSide(rl);
        rr = (($urandom_range(0, 3) == 0) ? rl : randSide(rr));
        applyStimulus(1'b0, rl, rr);
      end
    end

    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
